// File: rtl/vga_timing_out_if.sv
// vga_timing_out_if
// Pixel-side and DAC-side signals of the 640x480 raster timing/output stage.
// The master modport is the timing generator. The slave modport is its
// environment: the PPU that supplies colour, and the DAC pins as seen from
// the board.
interface vga_timing_out_if;
  logic [23:0] ppu_rgb;
  logic [9:0]  hcount;
  logic [9:0]  vcount;
  logic        frame_start;
  logic [7:0]  VGA_R;
  logic [7:0]  VGA_G;
  logic [7:0]  VGA_B;
  logic        VGA_CLK;
  logic        VGA_HS;
  logic        VGA_VS;
  logic        VGA_BLANK_n;
  logic        VGA_SYNC_n;

  modport master (
    input  ppu_rgb,
    output hcount, vcount, frame_start,
    output VGA_R, VGA_G, VGA_B, VGA_CLK,
    output VGA_HS, VGA_VS, VGA_BLANK_n, VGA_SYNC_n
  );

  modport slave (
    output ppu_rgb,
    input  hcount, vcount, frame_start,
    input  VGA_R, VGA_G, VGA_B, VGA_CLK,
    input  VGA_HS, VGA_VS, VGA_BLANK_n, VGA_SYNC_n
  );
endinterface

// File: rtl/vga_timing_out.sv
// vga_timing_out
// 640x480@60 raster timing generator and DAC output stage. The design runs on
// the 50 MHz clk, and a 1-bit phase toggle gives a 25 MHz pixel tick. The
// hcount/vcount coordinates feed the PPU. Sync and blank are delayed by
// PPU_LATENCY clks so that they line up with the colour returned on ppu_rgb.
// One output register then drives the ADV7123 pins, so every pin appears
// PPU_LATENCY+1 clks after the coordinate change.
// Optional build macro: VGA_TEST_PATTERN_EN replaces the active-area colour
// with 8 vertical colour bars of 80 pixels each.
module vga_timing_out #(
  parameter int PPU_LATENCY = 2
) (
  input  logic             clk,
  input  logic             reset,
  vga_timing_out_if.master bus
);

  // Horizontal raster (pixels): active, front porch, sync, back porch.
  localparam logic [9:0] H_ACTIVE     = 10'd640;
  localparam logic [9:0] H_SYNC_START = 10'd656;
  localparam logic [9:0] H_SYNC_END   = 10'd751;
  localparam logic [9:0] H_LAST       = 10'd799;

  // Vertical raster (lines).
  localparam logic [9:0] V_ACTIVE     = 10'd480;
  localparam logic [9:0] V_SYNC_START = 10'd490;
  localparam logic [9:0] V_SYNC_END   = 10'd491;
  localparam logic [9:0] V_LAST       = 10'd524;

  // One pipeline stage of the decoded raster signals.
  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       act;
`ifdef VGA_TEST_PATTERN_EN
    logic [2:0] bar;
`endif
  } stage_t;

  // Idle stage: syncs inactive (high), outside the active area.
`ifdef VGA_TEST_PATTERN_EN
  localparam stage_t STAGE_IDLE = '{hs: 1'b1, vs: 1'b1, act: 1'b0, bar: 3'd0};
`else
  localparam stage_t STAGE_IDLE = '{hs: 1'b1, vs: 1'b1, act: 1'b0};
`endif

  logic        phase;
  logic [9:0]  h_q;
  logic [9:0]  v_q;
  logic        frame_start_q;
  stage_t      raw;
  stage_t      dly;
  logic [23:0] pix_rgb;
  logic [23:0] rgb_q;
  logic        hs_q;
  logic        vs_q;
  logic        blank_n_q;
  logic        vga_clk_q;

`ifdef VGA_TEST_PATTERN_EN
  // Bar index h/80 for the active columns 0..639. Columns past 639 are
  // blanked, so the value there does not matter.
  function automatic logic [2:0] bar_index(input logic [9:0] h);
    logic [2:0] idx;
    idx = 3'd7;
    if      (h < 10'd80)  idx = 3'd0;
    else if (h < 10'd160) idx = 3'd1;
    else if (h < 10'd240) idx = 3'd2;
    else if (h < 10'd320) idx = 3'd3;
    else if (h < 10'd400) idx = 3'd4;
    else if (h < 10'd480) idx = 3'd5;
    else if (h < 10'd560) idx = 3'd6;
    return idx;
  endfunction

  // Colour bars, left to right: white, yellow, cyan, green, magenta, red,
  // blue, black.
  function automatic logic [23:0] bar_colour(input logic [2:0] idx);
    logic [23:0] c;
    case (idx)
      3'd0:    c = 24'hffffff;
      3'd1:    c = 24'hffff00;
      3'd2:    c = 24'h00ffff;
      3'd3:    c = 24'h00ff00;
      3'd4:    c = 24'hff00ff;
      3'd5:    c = 24'hff0000;
      3'd6:    c = 24'h0000ff;
      default: c = 24'h000000;
    endcase
    return c;
  endfunction
`endif

  // Pixel phase and raster counters. The counters advance on the phase==1
  // edge, and frame_start marks the edge on which they take 0/0.
  always_ff @(posedge clk) begin
    // NOTE: all state uses non-blocking assignments, so every register in
    // this edge reads the values from before the edge.
    if (!reset) begin
      phase         <= 1'b0;
      h_q           <= '0;
      v_q           <= '0;
      frame_start_q <= 1'b0;
    end else begin
      phase         <= ~phase;
      frame_start_q <= 1'b0;
      if (phase) begin
        if (h_q == H_LAST) begin
          h_q <= '0;
          if (v_q == V_LAST) begin
            v_q           <= '0;
            frame_start_q <= 1'b1;
          end else begin
            v_q <= v_q + 10'd1;
          end
        end else begin
          h_q <= h_q + 10'd1;
        end
      end
    end
  end

  // Decode raw sync, active and bar signals from the current coordinates.
  always_comb begin
    // NOTE: start from a full default so that no path leaves a field
    // unassigned and infers a latch.
    raw     = STAGE_IDLE;
    raw.hs  = !((h_q >= H_SYNC_START) && (h_q <= H_SYNC_END));
    raw.vs  = !((v_q >= V_SYNC_START) && (v_q <= V_SYNC_END));
    raw.act = (h_q < H_ACTIVE) && (v_q < V_ACTIVE);
`ifdef VGA_TEST_PATTERN_EN
    raw.bar = bar_index(h_q);
`endif
  end

  // Delay line matching the PPU pipeline depth.
  if (PPU_LATENCY == 0) begin : g_no_delay
    assign dly = raw;
  end else begin : g_delay
    stage_t pipe [PPU_LATENCY];

    // Shift the decoded stage one place per clk.
    always_ff @(posedge clk) begin
      // NOTE: every stage is reset, not just the head. Stale contents would
      // otherwise reach the sync pins for PPU_LATENCY clks after reset.
      if (!reset) begin
        for (int i = 0; i < PPU_LATENCY; i++) pipe[i] <= STAGE_IDLE;
      end else begin
        pipe[0] <= raw;
        for (int i = 1; i < PPU_LATENCY; i++) pipe[i] <= pipe[i-1];
      end
    end

    assign dly = pipe[PPU_LATENCY-1];
  end

  // Colour source for the active area.
`ifdef VGA_TEST_PATTERN_EN
  assign pix_rgb = bar_colour(dly.bar);
`else
  assign pix_rgb = bus.ppu_rgb;
`endif

  // Output register. It drives the DAC pins; colour is forced to 0 while
  // blanked. VGA_CLK is phase delayed one clk, so the DAC's rising edge falls
  // mid-pixel.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rgb_q     <= '0;
      hs_q      <= 1'b1;
      vs_q      <= 1'b1;
      blank_n_q <= 1'b0;
      vga_clk_q <= 1'b0;
    end else begin
      rgb_q     <= dly.act ? pix_rgb : 24'h000000;
      hs_q      <= dly.hs;
      vs_q      <= dly.vs;
      blank_n_q <= dly.act;
      vga_clk_q <= phase;
    end
  end

  assign bus.hcount      = h_q;
  assign bus.vcount      = v_q;
  assign bus.frame_start = frame_start_q;
  assign bus.VGA_R       = rgb_q[23:16];
  assign bus.VGA_G       = rgb_q[15:8];
  assign bus.VGA_B       = rgb_q[7:0];
  assign bus.VGA_CLK     = vga_clk_q;
  assign bus.VGA_HS      = hs_q;
  assign bus.VGA_VS      = vs_q;
  assign bus.VGA_BLANK_n = blank_n_q;
  assign bus.VGA_SYNC_n  = 1'b0;

endmodule

// File: tb/tb_vga_timing_out.sv
// tb_vga_timing_out
// Directed bench for vga_timing_out with the default PPU_LATENCY of 2. A
// table of pixel positions is checked against hand-computed pin values three
// clks after each coordinate change. Hand sequences then cover reset, line
// wrap, frame wrap, sync pulse widths and reset mid-frame. A frame is 840k
// clks, so the bench jumps the raster counters to positions of interest by
// briefly forcing them.
// Build with VGA_TEST_PATTERN_EN defined to check the colour-bar variant.
module tb_vga_timing_out;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  vga_timing_out_if bus ();

  vga_timing_out #(.PPU_LATENCY(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #10 clk = ~clk;

  // PPU model: a 2-clk pipeline that returns {h[7:0], v[7:0], 5a}, or
  // constant white when ppu_white is set.
  logic        ppu_white = 1'b0;
  logic [23:0] ppu_s1 = '0;
  logic [23:0] ppu_s2 = '0;
  always @(posedge clk) begin
    ppu_s1 <= {bus.hcount[7:0], bus.vcount[7:0], 8'h5a};
    ppu_s2 <= ppu_s1;
  end
  assign bus.ppu_rgb = ppu_white ? 24'hffffff : ppu_s2;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  function automatic logic [23:0] pick(input logic [23:0] normal,
                                       input logic [23:0] pattern);
`ifdef VGA_TEST_PATTERN_EN
    return pattern;
`else
    return normal;
`endif
  endfunction

  function automatic logic [23:0] pins_rgb();
    return {bus.VGA_R, bus.VGA_G, bus.VGA_B};
  endfunction

  function automatic logic [2:0] pins_sync();
    return {bus.VGA_HS, bus.VGA_VS, bus.VGA_BLANK_n};
  endfunction

  // Jump target. Force needs static variables on its right-hand side.
  logic [9:0] jump_h;
  logic [9:0] jump_v;

  // Load the counters mid-cycle while phase==0. Two clks then pass before the
  // next tick.
  task automatic jump_to(input logic [9:0] h, input logic [9:0] v);
    @(negedge clk);
    if (dut.phase !== 1'b0) @(negedge clk);
    jump_h = h;
    jump_v = v;
    force dut.h_q = jump_h;
    force dut.v_q = jump_v;
    #1;
    release dut.h_q;
    release dut.v_q;
  endtask

  task automatic edges(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Stop at the edge on which the counters become (h,v), within a bound.
  task automatic wait_coord(input logic [9:0] h, input logic [9:0] v,
                            input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(posedge clk);
      #1;
      if (bus.hcount == h && bus.vcount == v) ok = 1'b1;
    end
  endtask

  typedef struct {
    logic [9:0]  h;
    logic [9:0]  v;
    logic        white;
    logic [23:0] rgb;
    logic [2:0]  sync;  // {VGA_HS, VGA_VS, VGA_BLANK_n}
  } vec_t;

  localparam int NV = 15;
  vec_t vecs [NV];

  // Watchdog: the whole run is a few thousand clks.
  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit         ok;
    logic [9:0] ph;
    logic [9:0] pv;
    int         lo_count;
    int         first_lo;
    int         fs_count;
    bit         fs_origin;

    vecs[0]  = '{10'd37,  10'd12,  1'b0, pick(24'h250c5a, 24'hffffff), 3'b111};
    vecs[1]  = '{10'd639, 10'd0,   1'b0, pick(24'h7f005a, 24'h000000), 3'b111};
    vecs[2]  = '{10'd640, 10'd0,   1'b0, 24'h000000, 3'b110};
    vecs[3]  = '{10'd656, 10'd5,   1'b1, 24'h000000, 3'b010};
    vecs[4]  = '{10'd751, 10'd5,   1'b1, 24'h000000, 3'b010};
    vecs[5]  = '{10'd752, 10'd5,   1'b1, 24'h000000, 3'b110};
    vecs[6]  = '{10'd0,   10'd479, 1'b0, pick(24'h00df5a, 24'hffffff), 3'b111};
    vecs[7]  = '{10'd0,   10'd480, 1'b1, 24'h000000, 3'b110};
    vecs[8]  = '{10'd100, 10'd490, 1'b1, 24'h000000, 3'b100};
    vecs[9]  = '{10'd700, 10'd491, 1'b1, 24'h000000, 3'b000};
    vecs[10] = '{10'd100, 10'd492, 1'b1, 24'h000000, 3'b110};
    vecs[11] = '{10'd320, 10'd240, 1'b1, pick(24'hffffff, 24'hff00ff), 3'b111};
    vecs[12] = '{10'd799, 10'd524, 1'b1, 24'h000000, 3'b110};
    vecs[13] = '{10'd85,  10'd30,  1'b1, pick(24'hffffff, 24'hffff00), 3'b111};
    vecs[14] = '{10'd559, 10'd100, 1'b0, pick(24'h2f645a, 24'h0000ff), 3'b111};

    // Reset held for 4 clks: all outputs at their reset values.
    reset = 1'b0;
    edges(4);
    check("rst hcount", 32'(bus.hcount), 32'd0);
    check("rst vcount", 32'(bus.vcount), 32'd0);
    check("rst frame_start", 32'(bus.frame_start), 32'd0);
    check("rst rgb", 32'(pins_rgb()), 32'h0);
    check("rst hs/vs/blank_n", 32'(pins_sync()), 32'b110);
    check("rst vga_clk", 32'(bus.VGA_CLK), 32'd0);
    check("sync_n tied low", 32'(bus.VGA_SYNC_n), 32'd0);

    // Release: hcount reaches 1 exactly 2 clks later.
    @(negedge clk);
    reset = 1'b1;
    edges(1);
    check("post-rst clk1 hcount", 32'(bus.hcount), 32'd0);
    check("post-rst clk1 vga_clk", 32'(bus.VGA_CLK), 32'd0);
    check("post-rst clk1 frame_start", 32'(bus.frame_start), 32'd0);
    edges(1);
    check("post-rst clk2 hcount", 32'(bus.hcount), 32'd1);
    check("post-rst clk2 vga_clk", 32'(bus.VGA_CLK), 32'd1);

    // Table: reach each pixel by a natural tick, then check the pins 3 clks
    // after the coordinate change.
    for (int i = 0; i < NV; i++) begin
      ppu_white = vecs[i].white;
      ph = (vecs[i].h == 10'd0) ? 10'd799 : vecs[i].h - 10'd1;
      pv = (vecs[i].h != 10'd0) ? vecs[i].v :
           (vecs[i].v == 10'd0) ? 10'd524 : vecs[i].v - 10'd1;
      jump_to(ph, pv);
      wait_coord(vecs[i].h, vecs[i].v, 8, ok);
      check($sformatf("vec%0d reach", i), 32'(ok), 32'd1);
      edges(3);
      check($sformatf("vec%0d rgb", i), 32'(pins_rgb()), 32'(vecs[i].rgb));
      check($sformatf("vec%0d hs/vs/blank_n", i), 32'(pins_sync()),
            32'(vecs[i].sync));
    end

    // Colour alignment: pixel (37,12) is not on the pins 2 clks after the
    // change; pixel 36 still is. It appears at 3 clks.
    ppu_white = 1'b0;
    jump_to(10'd36, 10'd12);
    wait_coord(10'd37, 10'd12, 8, ok);
    check("align reach", 32'(ok), 32'd1);
    edges(2);
    check("align +2 rgb", 32'(pins_rgb()), 32'(pick(24'h240c5a, 24'hffffff)));
    edges(1);
    check("align +3 rgb", 32'(pins_rgb()), 32'(pick(24'h250c5a, 24'hffffff)));

    // Line wrap 799/10 -> 0/11.
    jump_to(10'd799, 10'd10);
    wait_coord(10'd0, 10'd11, 8, ok);
    check("line wrap to 0/11", 32'(ok), 32'd1);

    // HS low for 192 clks per line, starting 3 clks after hcount becomes 656.
    jump_to(10'd655, 10'd20);
    wait_coord(10'd656, 10'd20, 8, ok);
    check("hs reach 656", 32'(ok), 32'd1);
    lo_count = 0;
    first_lo = -1;
    for (int k = 1; k <= 1600; k++) begin
      edges(1);
      if (bus.VGA_HS == 1'b0) begin
        lo_count++;
        if (first_lo < 0) first_lo = k;
      end
    end
    check("hs low start offset", 32'(first_lo), 32'd3);
    check("hs low clks per line", 32'(lo_count), 32'd192);

    // VS low for 3200 clks around the vertical sync lines.
    jump_to(10'd790, 10'd489);
    lo_count = 0;
    for (int k = 0; k < 3600; k++) begin
      edges(1);
      if (bus.VGA_VS == 1'b0) lo_count++;
    end
    check("vs low clks per frame", 32'(lo_count), 32'd3200);

    // Frame wrap 799/524 -> 0/0 with a single frame_start on the same edge.
    jump_to(10'd799, 10'd524);
    fs_count  = 0;
    fs_origin = 1'b0;
    for (int k = 0; k < 24; k++) begin
      edges(1);
      if (bus.frame_start) begin
        fs_count++;
        if (bus.hcount == 10'd0 && bus.vcount == 10'd0) fs_origin = 1'b1;
      end
    end
    check("frame_start pulse count", 32'(fs_count), 32'd1);
    check("frame_start at 0/0", 32'(fs_origin), 32'd1);

    // Reset mid-frame at 300/200: the next edge restores every reset value.
    ppu_white = 1'b0;
    jump_to(10'd300, 10'd200);
    edges(4);
    @(negedge clk);
    reset = 1'b0;
    edges(1);
    check("mid rst hcount", 32'(bus.hcount), 32'd0);
    check("mid rst vcount", 32'(bus.vcount), 32'd0);
    check("mid rst frame_start", 32'(bus.frame_start), 32'd0);
    check("mid rst rgb", 32'(pins_rgb()), 32'h0);
    check("mid rst hs/vs/blank_n", 32'(pins_sync()), 32'b110);
    check("mid rst vga_clk", 32'(bus.VGA_CLK), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    wait_coord(10'd85, 10'd0, 200, ok);
    check("post mid rst reach 85/0", 32'(ok), 32'd1);
    edges(3);
    check("post mid rst pixel 85", 32'(pins_rgb()),
          32'(pick(24'h55005a, 24'hffff00)));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_timing_out.md
# vga_timing_out

Raster timing generator and pixel output stage for the 640x480 display path. It produces the `hcount`/`vcount` pixel coordinates consumed by the PPU and sprite display modules. It then accepts the PPU's mixed 24-bit colour, aligns it with delayed sync/blank signals and drives the ADV7123 DAC pins. It runs from the 50 MHz system clock with a 2-cycle pixel enable (25 MHz pixel rate).

## Interface
- `PPU_LATENCY`, default 2: clk cycles from a coordinate change on `hcount`/`vcount` to the matching colour on `ppu_rgb`; legal range 0..7.
- `clk`  input  1: 50 MHz system clock.
- `reset`  input  1: synchronous, active-low reset; sampled on rising `clk`.
- `ppu_rgb`  input  24: PPU output colour, {R[23:16], G[15:8], B[7:0]}.
- `hcount`  output  10: current pixel column, 0..799.
- `vcount`  output  10: current line, 0..524.
- `frame_start`  output  1: one-clk pulse when `hcount`/`vcount` become 0/0.
- `VGA_R`, `VGA_G`, `VGA_B`  output  8 each: DAC colour.
- `VGA_CLK`  output  1: 25 MHz pixel clock to the DAC.
- `VGA_HS`, `VGA_VS`  output  1 each: active-low syncs.
- `VGA_BLANK_n`  output  1: low outside the active area.
- `VGA_SYNC_n`  output  1: tied 0.

## Operation
- `phase` is a 1-bit toggle. It is 0 after reset and inverts every clk. The pixel tick is `phase==1`.
- On a tick, `hcount` increments. At 799 it wraps to 0 and `vcount` increments. `vcount` wraps 524 -> 0.
- Horizontal timing:
  - active 0..639
  - front porch 640..655
  - sync 656..751
  - back porch 752..799
- Vertical timing:
  - active 0..479
  - front porch 480..489
  - sync 490..491
  - back porch 492..524
- Raw signals are decoded combinationally from the counters:
  - `hs_raw` = !(656<=h<=751)
  - `vs_raw` = !(490<=v<=491)
  - `act_raw` = (h<640)&&(v<480)
- `hs_raw`, `vs_raw` and `act_raw` pass through a shift register of depth `PPU_LATENCY`. The delayed values line up with `ppu_rgb`.
- Output register, updated every clk:
  - `VGA_HS`/`VGA_VS`/`VGA_BLANK_n` take the delayed values.
  - `VGA_R/G/B` take `ppu_rgb` when the delayed active bit is 1, otherwise 0.
- `VGA_CLK` is registered `phase`. The DAC latches on its rising edge, which is mid-pixel.
- `frame_start` is registered and asserted for the clk in which the counters take 0/0.
- Reset values:
  - `hcount`=0, `vcount`=0, `phase`=0, `frame_start`=0
  - all delay stages: hs=1, vs=1, act=0
  - `VGA_R/G/B`=0, `VGA_HS`=1, `VGA_VS`=1, `VGA_BLANK_n`=0, `VGA_CLK`=0
- Reset mid-line: on the next clk edge every state element takes its reset value. There is no partial frame, and the first post-reset frame starts at 0/0. `frame_start` is not pulsed by reset itself.
- `ppu_rgb` is never stored beyond the single output register. A colour of 0x9290ff (sky) is passed through unmodified.

## Timing
- Counter update: every other clk, at the edge where `phase` goes 1 -> 0.
- Colour path latency: the pin value appears `PPU_LATENCY+1` clks after the coordinate change. This is 3 clks with the default.
- Sync/blank latency equals the colour latency, so the relative alignment is exact.
- Line period 1600 clks. Frame period 840 000 clks (59.52 Hz).
- The `hcount`/`vcount` 799/524 -> 0/0 transition and `frame_start` assertion occur on the same edge.

## Configuration
- `VGA_TEST_PATTERN_EN` defined:
  - the output mux ignores `ppu_rgb` in the active area;
  - it emits 8 vertical colour bars of 80 pixels each, selected by delayed `hcount[9:7]`-equivalent bar index (h/80);
  - colours in order: ffffff, ffff00, 00ffff, 00ff00, ff00ff, ff0000, 0000ff, 000000;
  - the bar index is delayed with the sync pipeline so bars align identically.
- `VGA_TEST_PATTERN_EN` undefined: `ppu_rgb` drives the colour. No test-pattern logic is present.

## Test plan
- Reset: hold `reset`=0 for 4 clks, then release -> all outputs at reset values; `hcount` becomes 1 exactly 2 clks after release.
- Line wrap: run to `hcount`=799, `vcount`=10 -> next tick gives `hcount`=0, `vcount`=11; `VGA_HS` is low for exactly 192 clks per line, starting 3 clks after `hcount` becomes 656.
- Frame wrap: run to 799/524 -> next tick gives 0/0 and a single 1-clk `frame_start`; `VGA_VS` is low for 3200 clks per frame.
- Colour alignment: model PPU with a 2-clk pipeline returning {hcount[7:0], vcount[7:0], 8'h5a} -> at pixel (37,12) the pins show R=0x25, G=0x0c, B=0x5a 3 clks after the coordinate change.
- Blanking: drive `ppu_rgb`=0xffffff constantly -> RGB=0 and `VGA_BLANK_n`=0 for every clk during h>=640 or v>=480 (delayed 3 clks).
- Reset mid-frame at 300/200 -> next edge gives 0/0 with reset output values; with `VGA_TEST_PATTERN_EN` defined, pixel 85 displays ffff00.
